// File: rtl/bufferdomain_pkg.sv
// Shared constants and helpers for the LPC-to-system-clock word FIFO.
package bufferdomain_pkg;

  localparam int DROP_CNT_W   = 8;
  localparam int DROP_CNT_MAX = 255;

  // Pointer width including the wrap bit used to tell full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bufferdomain_fifo_strobe_sync.sv
// Synchroniser plus rising-edge detector for an asynchronous strobe.
// The chain resets to 1, so a strobe already high at reset release is not seen as an edge.
module strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge_q;

  // Stage boundary: metastability chain, then one registered copy for edge detect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync   <= '1;
      r_edge_q <= 1'b1;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_edge_q <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise_pulse = r_sync[SYNC_STAGES-1] & ~r_edge_q;

endmodule

// File: rtl/bufferdomain_fifo.sv
// Moves strobed LPC words into the system clock domain through a DEPTH-entry FIFO.
// Optional acceptance filter enabled with macro BUFFERDOMAIN_FILTER_EN.
module bufferdomain_fifo
  import bufferdomain_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
`ifdef BUFFERDOMAIN_FILTER_EN
  ,
  parameter logic [AW-1:0] FILTER_MASK  = '0,
  parameter logic [AW-1:0] FILTER_MATCH = '0
`endif
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [AW-1:0]           input_data,
  input  logic                    input_enable,
  output logic [AW-1:0]           output_data,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic                    overflow,
  input  logic                    overflow_clear,
  output logic [DROP_CNT_W-1:0]   drop_count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int IW = PW - 1;
  localparam logic [DROP_CNT_W-1:0] DROP_MAX_V = DROP_CNT_W'(DROP_CNT_MAX);

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == DROP_MAX_V) ? v : v + DROP_CNT_W'(1);
  endfunction

  logic [AW-1:0]         r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_fill;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic          w_push_req;
  logic          w_accept;
  logic          w_push_cand;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [PW-1:0] w_wr_nxt;
  logic [PW-1:0] w_rd_nxt;

  strobe_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_strobe_sync (
    .clock      (clock),
    .reset      (reset),
    .async_in   (input_enable),
    .rise_pulse (w_push_req)
  );

`ifdef BUFFERDOMAIN_FILTER_EN
  assign w_accept = ((input_data & FILTER_MASK) == FILTER_MATCH);
`else
  assign w_accept = 1'b1;
`endif

  assign w_push_cand = w_push_req & w_accept;
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                       (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]);
  assign w_pop       = ~w_empty & output_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push      = w_push_cand & (~w_full | w_pop);
  assign w_drop      = w_push_cand & w_full & ~w_pop;

  assign w_wr_nxt = w_push ? r_wr_ptr + PW'(1) : r_wr_ptr;
  assign w_rd_nxt = w_pop  ? r_rd_ptr + PW'(1) : r_rd_ptr;

  // Stage boundary: pointer and occupancy registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_fill   <= w_wr_nxt - w_rd_nxt;
    end
  end

  // Storage is data-only and deliberately left unreset.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr[IW-1:0]] <= input_data;
    end
  end

  // Stage boundary: sticky overflow flag and saturating drop counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      r_drop_cnt <= overflow_clear ? DROP_CNT_W'(1) : sat_inc(r_drop_cnt);
    end else if (overflow_clear) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign output_data  = r_mem[r_rd_ptr[IW-1:0]];
  assign output_valid = ~w_empty;
  assign fill_level   = r_fill;
  assign overflow     = r_overflow;
  assign drop_count   = r_drop_cnt;

endmodule

// File: tb/tb_bufferdomain_fifo.sv
// Self-checking bench for bufferdomain_fifo: directed steps plus randomized traffic
// compared against a queue-based reference model.
module tb_bufferdomain_fifo;

  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
`ifdef BUFFERDOMAIN_FILTER_EN
  localparam logic [AW-1:0] FMASK  = 32'h0FF0_0000;
  localparam logic [AW-1:0] FMATCH = 32'h0A40_0000;
`else
  localparam logic [AW-1:0] FMASK  = 32'h0;
  localparam logic [AW-1:0] FMATCH = 32'h0;
`endif

  logic                  clock = 1'b0;
  logic                  reset;
  logic [AW-1:0]         input_data;
  logic                  input_enable;
  logic [AW-1:0]         output_data;
  logic                  output_valid;
  logic                  output_ready;
  logic [$clog2(DEPTH):0] fill_level;
  logic                  overflow;
  logic                  overflow_clear;
  logic [7:0]            drop_count;

  always #5 clock = ~clock;

  bufferdomain_fifo #(
    .AW          (AW),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
`ifdef BUFFERDOMAIN_FILTER_EN
    ,
    .FILTER_MASK  (FMASK),
    .FILTER_MATCH (FMATCH)
`endif
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .input_data     (input_data),
    .input_enable   (input_enable),
    .output_data    (output_data),
    .output_valid   (output_valid),
    .output_ready   (output_ready),
    .fill_level     (fill_level),
    .overflow       (overflow),
    .overflow_clear (overflow_clear),
    .drop_count     (drop_count)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: words in arrival order, plus overflow bookkeeping.
  logic [AW-1:0] mq[$];
  bit            m_ovf;
  int            m_drop;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_accept(input logic [AW-1:0] d);
    return (d & FMASK) == FMATCH;
  endfunction

  function automatic void model_push(input logic [AW-1:0] d);
    if (model_accept(d)) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else begin
        m_ovf  = 1'b1;
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_valid"}, 64'(output_valid), 64'(mq.size() != 0));
    check({tag, "_fill"},  64'(fill_level),   64'(mq.size()));
    check({tag, "_ovf"},   64'(overflow),     64'(m_ovf));
    check({tag, "_drop"},  64'(drop_count),   64'(m_drop));
    if (mq.size() != 0) check({tag, "_head"}, 64'(output_data), 64'(mq[0]));
  endtask

  // Full strobe: rise, hold past the push, then fall long enough to re-arm the edge detector.
  task automatic strobe(input logic [AW-1:0] d, input string tag);
    input_data   = d;
    input_enable = 1'b1;
    repeat (SYNC + 3) @(negedge clock);
    input_enable = 1'b0;
    repeat (SYNC + 1) @(negedge clock);
    model_push(d);
    check_state(tag);
  endtask

  task automatic pop(input string tag);
    output_ready = 1'b1;
    if (mq.size() != 0) check({tag, "_popdata"}, 64'(output_data), 64'(mq[0]));
    @(negedge clock);
    output_ready = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
    check_state(tag);
  endtask

  task automatic clear(input string tag);
    overflow_clear = 1'b1;
    @(negedge clock);
    overflow_clear = 1'b0;
    m_ovf  = 1'b0;
    m_drop = 0;
    check_state(tag);
  endtask

  initial begin
    logic [AW-1:0] d;
    int            r;

    reset          = 1'b0;
    input_data     = 32'hA5A5_A5A5;
    input_enable   = 1'b1;
    output_ready   = 1'b0;
    overflow_clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check_state("reset");

    // Strobe already high at reset release must not push.
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("held_high_valid", 64'(output_valid), 64'd0);
    end
    check("held_high_fill", 64'(fill_level), 64'd0);
    input_enable = 1'b0;
    repeat (SYNC + 1) @(negedge clock);

    // Single strobe latency: valid appears exactly SYNC+1 clocks after the rise.
    input_data   = 32'h0A41_2345;
    input_enable = 1'b1;
    repeat (SYNC) @(negedge clock);
    check("lat_early", 64'(output_valid), 64'd0);
    @(negedge clock);
    check("lat_valid", 64'(output_valid), 64'd1);
    check("lat_data",  64'(output_data),  64'h0A41_2345);
    check("lat_fill",  64'(fill_level),   64'd1);
    mq.push_back(32'h0A41_2345);
    repeat (SYNC) @(negedge clock);
    input_enable = 1'b0;
    repeat (SYNC + 1) @(negedge clock);
    check_state("single_hold");
    pop("single_pop");
    check("single_empty", 64'(output_valid), 64'd0);

`ifdef BUFFERDOMAIN_FILTER_EN
    strobe(32'h0A40_00FF, "filt_pass");
    strobe(32'h0B40_0000, "filt_reject");
    check("filt_fill", 64'(fill_level),  64'd1);
    check("filt_data", 64'(output_data), 64'h0A40_00FF);
    check("filt_ovf",  64'(overflow),    64'd0);
    check("filt_drop", 64'(drop_count),  64'd0);
    pop("filt_pop");
`else
    // Overflow: six words into four slots.
    for (int i = 1; i <= 6; i++) strobe(AW'(i), "ovf_fill");
    check("ovf_fill4", 64'(fill_level), 64'd4);
    check("ovf_flag",  64'(overflow),   64'd1);
    check("ovf_drop2", 64'(drop_count), 64'd2);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_order", 64'(output_data), 64'(i));
      pop("ovf_drain");
    end
    clear("ovf_clear");
    check("ovf_cleared_flag", 64'(overflow),   64'd0);
    check("ovf_cleared_drop", 64'(drop_count), 64'd0);

    // Full FIFO: push and pop land on the same edge, nothing dropped.
    for (int i = 0; i < 4; i++) strobe(AW'(32'h11 + i), "simul_fill");
    input_data   = 32'h15;
    input_enable = 1'b1;
    repeat (SYNC) @(negedge clock);
    output_ready = 1'b1;
    check("simul_head", 64'(output_data), 64'h11);
    @(negedge clock);
    output_ready = 1'b0;
    check("simul_fill4", 64'(fill_level), 64'd4);
    check("simul_ovf",   64'(overflow),   64'd0);
    check("simul_drop",  64'(drop_count), 64'd0);
    void'(mq.pop_front());
    mq.push_back(32'h15);
    repeat (SYNC) @(negedge clock);
    input_enable = 1'b0;
    repeat (SYNC + 1) @(negedge clock);
    check_state("simul_after");
    for (int i = 0; i < 4; i++) begin
      check("simul_order", 64'(output_data), 64'(32'h12 + i));
      pop("simul_drain");
    end

    // Drop counter saturation, then clear colliding with a drop.
    for (int i = 0; i < 304; i++) strobe($urandom, "sat_fill");
    check("sat_drop", 64'(drop_count), 64'd255);
    check("sat_ovf",  64'(overflow),   64'd1);
    input_data   = $urandom;
    input_enable = 1'b1;
    repeat (SYNC) @(negedge clock);
    overflow_clear = 1'b1;
    @(negedge clock);
    overflow_clear = 1'b0;
    check("clr_drop_ovf",  64'(overflow),   64'd1);
    check("clr_drop_cnt",  64'(drop_count), 64'd1);
    m_ovf  = 1'b1;
    m_drop = 1;
    repeat (SYNC) @(negedge clock);
    input_enable = 1'b0;
    repeat (SYNC + 1) @(negedge clock);
    check_state("clr_drop_after");
    for (int i = 0; i < 4; i++) pop("sat_drain");
    clear("sat_clear");
`endif

    // Randomized mix of strobes, pops (including on empty) and clears.
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        d = $urandom;
        if ($urandom_range(0, 1) == 1) d = (d & ~FMASK) | FMATCH;
        strobe(d, "rnd_strobe");
      end else if (r < 9) begin
        pop("rnd_pop");
      end else begin
        clear("rnd_clear");
      end
    end

    // Reset in the middle of a strobe: FIFO empties, in-flight word is lost.
    strobe(FMATCH | 32'h1, "mid_pre1");
    strobe(FMATCH | 32'h2, "mid_pre2");
    input_data   = FMATCH | 32'h3;
    input_enable = 1'b1;
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_state("mid_reset");
    @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    check_state("mid_after");
    input_enable = 1'b0;
    repeat (SYNC + 1) @(negedge clock);
    check_state("mid_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
